dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single data_memory instance between the pipeline MEM stage (port 0) and the loader/debug master (port 1).
- Each cycle it selects at most one requester and drives the memory's mem_read/mem_write/address/write_data.
- It captures read data on the clock edge and returns it with a one-cycle rvalid pulse.
- Supports fixed-priority mode with a starvation guard, and round-robin mode.

Parameters:
- ADDR_W, 16, address width of memory and requester ports
- DATA_W, 16, data width
- ARB_MODE, 0, 0 = fixed priority (port 0 wins), 1 = round-robin
- STARVE_MAX, 4, fixed mode only: cycles port 1 may wait before a forced grant; 0 disables the guard

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- p0_req  in  1  port 0 access request
- p0_we  in  1  port 0 write (1) / read (0)
- p0_addr  in  ADDR_W  port 0 address
- p0_wdata  in  DATA_W  port 0 write data
- p0_gnt  out  1  port 0 granted this cycle (combinational)
- p0_rvalid  out  1  port 0 read data valid (registered)
- p0_rdata  out  DATA_W  port 0 read data (registered)
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1
- mem_read  out  1  to data memory read enable
- mem_write  out  1  to data memory write enable
- mem_address  out  ADDR_W  to data memory address
- mem_write_data  out  DATA_W  to data memory write data
- mem_read_data  in  DATA_W  from data memory, combinational read result

Behaviour:
- Reset (rst_n low, asynchronous): p0_rvalid = p1_rvalid = 0, p0_rdata = p1_rdata = 0, last_gnt = 1 (so port 0 wins the first contention), starve_cnt = 0.
- While rst_n is low, both gnt outputs are 0 and all mem_* outputs are 0, so no write can reach memory.
- Grant is combinational from req, last_gnt, starve_cnt and rst_n; at most one gnt is high per cycle.
- The cycle in which gnt is high is the transaction cycle.
- No grant issued: mem_read = mem_write = 0, mem_address = 0, mem_write_data = 0.
- Grant issued: mem_address and mem_write_data come from the winner; mem_write = winner we; mem_read = !winner we.
- Fixed mode (ARB_MODE = 0):
  - port 0 wins when both request;
  - exception: when STARVE_MAX != 0 and starve_cnt == STARVE_MAX, port 1 wins that cycle.
- starve_cnt update:
  - +1 on each cycle with p1_req & !p1_gnt, saturating at STARVE_MAX;
  - cleared to 0 on p1_gnt or when p1_req is low;
  - held at 0 when ARB_MODE = 1 or STARVE_MAX = 0.
- Round-robin mode (ARB_MODE = 1): when both request, grant the port != last_gnt. A lone requester is always granted.
- last_gnt updates on every grant, in both modes.
- Read latency: at the posedge ending a granted read, px_rdata <= mem_read_data and px_rvalid <= 1.
  - rvalid is a single-cycle pulse.
  - rdata holds its value until that port's next granted read.
- A granted write produces no rvalid. Memory commits the write at the same posedge.
- Requester rule: hold req, we, addr and wdata stable until gnt is seen.
  - Dropping req before grant is a legal cancel, with no side effects.
  - Holding req after the grant cycle is treated as a new request.
- Back-to-back:
  - A port may be granted on consecutive cycles; rvalid then stays high on consecutive cycles, with new rdata each cycle.
  - A read granted to port 1 in the cycle after a port 0 read does not disturb p0_rdata.
- Reset asserted mid-transaction: the in-flight rvalid is cleared, no partial write occurs, and the arbiter returns to the reset state.

Decomposition:
- Package dmem_arb_pkg:
  - ARB_FIXED = 0, ARB_RR = 1;
  - PORT_CPU = 0, PORT_LDR = 1;
  - default widths ADDR_W / DATA_W = 16.
- One natural sub-module: dmem_arb_starve_ctr, the saturating wait counter with a force output.
- Grant logic, muxing and read-capture registers stay in dmem_arbiter.

Test Plan:
- Reset, then p0 read of addr 0 in cycle 1 with data_memory attached -> p0_gnt = 1 in cycle 1, mem_read = 1; cycle 2: p0_rvalid = 1, p0_rdata = 16'h0253; cycle 3: rvalid = 0, rdata still 16'h0253.
- Fixed mode, STARVE_MAX = 4, both ports request continuously -> p0 granted 4 cycles, p1 granted on the 5th, then p0 resumes; starve_cnt returns to 0.
- Round-robin mode, both ports request for 6 cycles -> grants alternate p0, p1, p0, p1, p0, p1.
- p1 write of 16'hBEEF to addr 16'h0010, then p0 read of addr 16'h0010 -> p1_rvalid never asserts; p0_rdata = 16'hBEEF one cycle after p0_gnt.
- p1 raises req for 2 cycles and drops it while p0 holds the grant -> no p1_gnt, no mem_write, starve_cnt back to 0.
- rst_n pulled low during a granted p0 write -> mem_write = 0 immediately, memory unchanged at that address, all rvalid = 0 until after release.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the data-memory arbiter.
// Port identifiers, arbitration mode codes and the default bus widths.
package dmem_arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_LDR = 1'b1
  } port_e;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of the consecutive cycles the loader port has been waiting.
// force_gnt is raised once the wait reaches STARVE_MAX.
module dmem_arb_starve_ctr #(
  parameter int STARVE_MAX = 4,
  parameter bit ENABLE     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic gnt,
  output logic force_gnt
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= MAX_C) ? v : v + 1'b1;
  endfunction

  // A grant or a withdrawn request ends the wait; disabled guard stays at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!ENABLE || !req || gnt) begin
      cnt <= '0;
    end else begin
      cnt <= sat_inc(cnt);
    end
  end

  assign force_gnt = ENABLE && (cnt == MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the MEM stage (port 0) and the loader (port 1).
// Grants are combinational; read data is captured on the transaction edge.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ARB_MODE   = ARB_FIXED,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam bit STARVE_EN = (ARB_MODE == ARB_FIXED) && (STARVE_MAX != 0);

  port_e last_gnt;
  logic  force_ldr;

  dmem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX),
    .ENABLE     (STARVE_EN)
  ) u_starve (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (p1_req),
    .gnt       (p1_gnt),
    .force_gnt (force_ldr)
  );

  // Grant decision; reset masks both grants so nothing reaches memory
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (rst_n) begin
      if (p0_req && p1_req) begin
        if (ARB_MODE == ARB_RR) begin
          if (last_gnt == PORT_CPU) p1_gnt = 1'b1;
          else                      p0_gnt = 1'b1;
        end else if (force_ldr) begin
          p1_gnt = 1'b1;
        end else begin
          p0_gnt = 1'b1;
        end
      end else begin
        p0_gnt = p0_req;
        p1_gnt = p1_req;
      end
    end
  end

  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    if (p0_gnt) begin
      mem_read       = !p0_we;
      mem_write      = p0_we;
      mem_address    = p0_addr;
      mem_write_data = p0_wdata;
    end else if (p1_gnt) begin
      mem_read       = !p1_we;
      mem_write      = p1_we;
      mem_address    = p1_addr;
      mem_write_data = p1_wdata;
    end
  end

  // Reset value favours the CPU port in the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= PORT_LDR;
    end else if (p0_gnt) begin
      last_gnt <= PORT_CPU;
    end else if (p1_gnt) begin
      last_gnt <= PORT_LDR;
    end
  end

  // Read-capture stage: data lands on the edge that ends the granted read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= p0_gnt && !p0_we;
      p1_rvalid <= p1_gnt && !p1_we;
      if (p0_gnt && !p0_we) p0_rdata <= mem_read_data;
      if (p1_gnt && !p1_we) p1_rdata <= mem_read_data;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a fixed-priority and a round-robin instance share stimulus,
// each with its own memory, and are compared against a cycle-level reference model.
module tb_dmem_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [15:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;

  logic        gnt0 [2], gnt1 [2], rv0 [2], rv1 [2], mrd_en [2], mwr [2];
  logic [15:0] rd0 [2], rd1 [2], maddr [2], mwd [2], mrd [2];
  logic [15:0] dmem [2][256];

  // reference model state, index 0 = fixed priority, 1 = round robin
  logic [15:0] ref_mem [2][256];
  int          last_win [2];
  int          wait_cnt [2];
  bit          e_rv0 [2], e_rv1 [2];
  logic [15:0] e_rd0 [2], e_rd1 [2];
  bit          eg0 [2], eg1 [2];
  logic [1:0]  hist [2];
  bit          obs_mw [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .ARB_MODE(0), .STARVE_MAX(STARVE)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(gnt0[0]), .p0_rvalid(rv0[0]), .p0_rdata(rd0[0]),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(gnt1[0]), .p1_rvalid(rv1[0]), .p1_rdata(rd1[0]),
    .mem_read(mrd_en[0]), .mem_write(mwr[0]), .mem_address(maddr[0]),
    .mem_write_data(mwd[0]), .mem_read_data(mrd[0]));

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .ARB_MODE(1), .STARVE_MAX(STARVE)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(gnt0[1]), .p0_rvalid(rv0[1]), .p0_rdata(rd0[1]),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(gnt1[1]), .p1_rvalid(rv1[1]), .p1_rdata(rd1[1]),
    .mem_read(mrd_en[1]), .mem_write(mwr[1]), .mem_address(maddr[1]),
    .mem_write_data(mwd[1]), .mem_read_data(mrd[1]));

  for (genvar k = 0; k < 2; k++) begin : g_mem
    assign mrd[k] = dmem[k][maddr[k][7:0]];
    always @(posedge clk) if (mwr[k]) dmem[k][maddr[k][7:0]] <= mwd[k];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_val(input int i);
    return 16'h0253 + 16'(i) * 16'h0101;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      last_win[k] = 1; wait_cnt[k] = 0;
      e_rv0[k] = 0; e_rv1[k] = 0; e_rd0[k] = '0; e_rd1[k] = '0;
    end
  endtask

  // Who gets the memory this cycle, from the arbitration rules
  task automatic model_grant(input int k, output bit g0, output bit g1);
    g0 = 0; g1 = 0;
    if (rst_n) begin
      if (p0_req && p1_req) begin
        if (k == 1) begin
          if (last_win[k] == 0) g1 = 1; else g0 = 1;
        end else if (wait_cnt[k] == STARVE) g1 = 1;
        else g0 = 1;
      end else begin
        g0 = p0_req; g1 = p1_req;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bit g0, g1, we;
      logic [15:0] a, d;
      string p;
      p = (k == 0) ? "fx_" : "rr_";
      model_grant(k, g0, g1);
      we = g0 ? p0_we : p1_we;
      a  = g0 ? p0_addr : (g1 ? p1_addr : 16'h0);
      d  = g0 ? p0_wdata : (g1 ? p1_wdata : 16'h0);
      if (!g0 && !g1) we = 0;
      check({p, "p0_gnt"}, gnt0[k], g0);
      check({p, "p1_gnt"}, gnt1[k], g1);
      check({p, "mem_read"}, mrd_en[k], (g0 | g1) & !we);
      check({p, "mem_write"}, mwr[k], (g0 | g1) & we);
      check({p, "mem_address"}, maddr[k], a);
      check({p, "mem_write_data"}, mwd[k], d);
      check({p, "p0_rvalid"}, rv0[k], e_rv0[k]);
      check({p, "p1_rvalid"}, rv1[k], e_rv1[k]);
      check({p, "p0_rdata"}, rd0[k], e_rd0[k]);
      check({p, "p1_rdata"}, rd1[k], e_rd1[k]);
      hist[k] = {gnt1[k], gnt0[k]};
      obs_mw[k] = mwr[k];
      eg0[k] = g0; eg1[k] = g1;
    end
    check("fx_starve_cnt", u_fix.u_starve.cnt, wait_cnt[0]);
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        e_rv0[k] = eg0[k] && !p0_we;
        e_rv1[k] = eg1[k] && !p1_we;
        if (e_rv0[k]) e_rd0[k] = ref_mem[k][p0_addr[7:0]];
        if (e_rv1[k]) e_rd1[k] = ref_mem[k][p1_addr[7:0]];
        if (eg0[k] && p0_we) ref_mem[k][p0_addr[7:0]] = p0_wdata;
        if (eg1[k] && p1_we) ref_mem[k][p1_addr[7:0]] = p1_wdata;
        if (eg0[k]) last_win[k] = 0;
        else if (eg1[k]) last_win[k] = 1;
      end
      if (p1_req && !eg1[0]) wait_cnt[0] = (wait_cnt[0] < STARVE) ? wait_cnt[0] + 1 : STARVE;
      else wait_cnt[0] = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    idle();
    step();
    rst_n = 1;
  endtask

  logic [1:0] fx_seq [6];
  logic [1:0] rr_seq [6];

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) begin
        dmem[k][i] = init_val(i);
        ref_mem[k][i] = init_val(i);
      end
    model_reset();
    step();
    step();
    rst_n = 1;

    // read of address 0 straight after reset
    p0_req = 1; p0_we = 0; p0_addr = 16'h0000;
    step();
    idle();
    check("tp_p0_rvalid", rv0[0], 1'b1);
    check("tp_p0_rdata", rd0[0], 16'h0253);
    step();
    check("tp_p0_rvalid_drop", rv0[0], 1'b0);
    check("tp_p0_rdata_hold", rd0[0], 16'h0253);

    // continuous contention: starvation guard and alternation
    do_reset();
    p0_req = 1; p0_addr = 16'h0001; p1_req = 1; p1_addr = 16'h0002;
    for (int i = 0; i < 6; i++) begin
      step();
      fx_seq[i] = hist[0];
      rr_seq[i] = hist[1];
      if (i == 4) check("fx_starve_clear", u_fix.u_starve.cnt, 0);
    end
    idle();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("fx_seq%0d", i), fx_seq[i], (i == 4) ? 2'b10 : 2'b01);
      check($sformatf("rr_seq%0d", i), rr_seq[i], (i % 2) ? 2'b10 : 2'b01);
    end
    step();

    // loader write, then CPU read of the same word
    p1_req = 1; p1_we = 1; p1_addr = 16'h0010; p1_wdata = 16'hBEEF;
    step();
    idle();
    p0_req = 1; p0_addr = 16'h0010;
    step();
    idle();
    check("fx_beef_rdata", rd0[0], 16'hBEEF);
    check("rr_beef_rdata", rd0[1], 16'hBEEF);
    check("fx_beef_p1_rvalid", rv1[0], 1'b0);
    step();

    // loader request withdrawn while the CPU keeps the memory
    do_reset();
    p0_req = 1; p0_addr = 16'h0003;
    p1_req = 1; p1_we = 1; p1_addr = 16'h0020; p1_wdata = 16'h5A5A;
    for (int i = 0; i < 2; i++) begin
      step();
      check("fx_cancel_no_p1", hist[0][1], 1'b0);
      check("fx_cancel_no_write", obs_mw[0], 1'b0);
    end
    p1_req = 0;
    step();
    check("fx_cancel_cnt", u_fix.u_starve.cnt, 0);
    idle();
    step();

    // reset pulled in the middle of a granted write
    p0_req = 1; p0_we = 1; p0_addr = 16'h0005; p0_wdata = 16'h1234;
    #2;
    rst_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_mem_write", mwr[k], 1'b0);
      check("rst_gnt", gnt0[k], 1'b0);
      check("rst_rvalid", rv0[k] | rv1[k], 1'b0);
    end
    model_reset();
    step();
    for (int k = 0; k < 2; k++) check("rst_mem_kept", dmem[k][5], ref_mem[k][5]);
    idle();
    rst_n = 1;
    step();

    // randomized traffic honouring the hold-until-granted rule
    for (int n = 0; n < 400; n++) begin
      if (p0_req && !(eg0[0] && eg0[1])) begin
        if ($urandom_range(0, 9) == 0) p0_req = 0;
      end else begin
        p0_req = ($urandom_range(0, 2) != 0);
        p0_we = $urandom_range(0, 1);
        p0_addr = 16'($urandom_range(0, 31));
        p0_wdata = 16'($urandom);
      end
      if (p1_req && !(eg1[0] && eg1[1])) begin
        if ($urandom_range(0, 9) == 0) p1_req = 0;
      end else begin
        p1_req = ($urandom_range(0, 2) != 0);
        p1_we = $urandom_range(0, 1);
        p1_addr = 16'($urandom_range(0, 31));
        p1_wdata = 16'($urandom);
      end
      if (n == 200) begin
        #2;
        rst_n = 0;
        model_reset();
        step();
        rst_n = 1;
      end else begin
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
